// File: rtl/lsu.sv
// Load/store unit: takes the execute-stage ALU result as an effective address
// (or passes it through), performs one outstanding aligned doubleword access
// on a valid/ready memory port, aligns/extends load data and hands a
// write-back packet to WB under valid/ready.
module lsu #(
    parameter int XLEN = 64,
    parameter int OP_W = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [OP_W-1:0] i_op,
    input  logic [XLEN-1:0] i_alu_res,
    input  logic [XLEN-1:0] i_sdata,
    input  logic            i_rdwen,
    input  logic [4:0]      i_rdid,
    output logic            o_mem_req_valid,
    input  logic            i_mem_req_ready,
    output logic [XLEN-1:0] o_mem_addr,
    output logic            o_mem_wen,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [7:0]      o_mem_wmask,
    input  logic            i_mem_rsp_valid,
    input  logic [XLEN-1:0] i_mem_rdata,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_rdwen,
    output logic [4:0]      o_rdid,
    output logic            o_misalign
);

    localparam logic [OP_W-1:0] OP_LB  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LH  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LW  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_LD  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LBU = OP_W'(5);
    localparam logic [OP_W-1:0] OP_LHU = OP_W'(6);
    localparam logic [OP_W-1:0] OP_LWU = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SB  = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SH  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_SW  = OP_W'(10);
    localparam logic [OP_W-1:0] OP_SD  = OP_W'(11);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return (op >= OP_LB) && (op <= OP_LWU);
    endfunction

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return (op >= OP_SB) && (op <= OP_SD);
    endfunction

    // Access size as log2(bytes): 0=byte, 1=half, 2=word, 3=double.
    function automatic logic [1:0] size_of(input logic [OP_W-1:0] op);
        logic [1:0] sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = 2'd0;
            OP_LH, OP_LHU, OP_SH: sz = 2'd1;
            OP_LW, OP_LWU, OP_SW: sz = 2'd2;
            default:              sz = 2'd3;
        endcase
        return sz;
    endfunction

    function automatic logic is_misaligned(input logic [OP_W-1:0] op,
                                           input logic [2:0]      off);
        logic mis;
        if (!(is_load(op) || is_store(op))) begin
            mis = 1'b0;
        end else begin
            case (size_of(op))
                2'd1:    mis = off[0];
                2'd2:    mis = |off[1:0];
                2'd3:    mis = |off;
                default: mis = 1'b0;
            endcase
        end
        return mis;
    endfunction

    // Pick the addressed lane out of the doubleword and sign/zero extend it.
    function automatic logic signed [XLEN-1:0] load_align(input logic [OP_W-1:0] op,
                                                          input logic [XLEN-1:0] rdata,
                                                          input logic [2:0]      off);
        logic [XLEN-1:0]        sh;
        logic signed [XLEN-1:0] r;
        sh = rdata >> {off, 3'b000};
        case (op)
            OP_LB:   r = {{56{sh[7]}},  sh[7:0]};
            OP_LH:   r = {{48{sh[15]}}, sh[15:0]};
            OP_LW:   r = {{32{sh[31]}}, sh[31:0]};
            OP_LBU:  r = {56'd0, sh[7:0]};
            OP_LHU:  r = {48'd0, sh[15:0]};
            OP_LWU:  r = {32'd0, sh[31:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] store_mask(input logic [OP_W-1:0] op,
                                              input logic [2:0]      off);
        logic [7:0] m;
        case (size_of(op))
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

    state_t          state_q, state_d;
    logic            accept;
    logic [OP_W-1:0] op_p0;
    logic [XLEN-1:0] addr_p0;
    logic [XLEN-1:0] sdata_p0;
    logic            rdwen_p0;
    logic [4:0]      rdid_p0;
    logic            misalign_p0;
    logic [XLEN-1:0] res_p1;
    logic [2:0]      off_p0;

    assign accept = i_valid && (state_q == S_IDLE);
    assign off_p0 = addr_p0[2:0];

    // State register; reset returns to IDLE from any state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: aligned memory ops go through REQ/WAIT, everything else
    // (NONE, unknown ops, misaligned accesses) goes straight to DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if ((is_load(i_op) || is_store(i_op)) &&
                        !is_misaligned(i_op, i_alu_res[2:0])) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_REQ:  if (i_mem_req_ready) state_d = S_WAIT;
            S_WAIT: if (i_mem_rsp_valid) state_d = S_DONE;
            S_DONE: if (i_ready)         state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // p0: packet fields captured at accept and held for the whole transaction.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            op_p0       <= i_op;
            addr_p0     <= i_alu_res;
            sdata_p0    <= i_sdata;
            rdwen_p0    <= i_rdwen;
            rdid_p0     <= i_rdid;
            misalign_p0 <= is_misaligned(i_op, i_alu_res[2:0]);
        end
    end

    // p1: result starts as the ALU value and is replaced by the load data
    // (or zero for a store ack) when the response arrives.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            res_p1 <= i_alu_res;
        end else if ((state_q == S_WAIT) && i_mem_rsp_valid) begin
            res_p1 <= is_load(op_p0) ? load_align(op_p0, i_mem_rdata, off_p0) : '0;
        end
    end

    // Outputs are qualified by state so that idle/reset values are all zero.
    always_comb begin
        o_ready         = (state_q == S_IDLE);
        o_mem_req_valid = 1'b0;
        o_mem_addr      = '0;
        o_mem_wen       = 1'b0;
        o_mem_wdata     = '0;
        o_mem_wmask     = '0;
        o_valid         = 1'b0;
        o_result        = '0;
        o_rdwen         = 1'b0;
        o_rdid          = '0;
        o_misalign      = 1'b0;
        if (state_q == S_REQ) begin
            o_mem_req_valid = 1'b1;
            o_mem_addr      = {addr_p0[XLEN-1:3], 3'b000};
            if (is_store(op_p0)) begin
                o_mem_wen   = 1'b1;
                o_mem_wdata = sdata_p0 << {off_p0, 3'b000};
                o_mem_wmask = store_mask(op_p0, off_p0);
            end
        end
        if (state_q == S_DONE) begin
            o_valid    = 1'b1;
            o_result   = res_p1;
            o_rdwen    = rdwen_p0 && !misalign_p0 && !is_store(op_p0);
            o_rdid     = rdid_p0;
            o_misalign = misalign_p0;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Randomized plus directed bench for lsu against a behavioural model that
// computes expected memory fields and write-back values from plain arithmetic.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_op;
    logic [63:0] i_alu_res;
    logic [63:0] i_sdata;
    logic        i_rdwen;
    logic [4:0]  i_rdid;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [63:0] o_mem_addr;
    logic        o_mem_wen;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_wmask;
    logic        i_mem_rsp_valid;
    logic [63:0] i_mem_rdata;
    logic        o_valid;
    logic        i_ready;
    logic [63:0] o_result;
    logic        o_rdwen;
    logic [4:0]  o_rdid;
    logic        o_misalign;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu #(.XLEN(64), .OP_W(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_alu_res(i_alu_res), .i_sdata(i_sdata),
        .i_rdwen(i_rdwen), .i_rdid(i_rdid),
        .o_mem_req_valid(o_mem_req_valid), .i_mem_req_ready(i_mem_req_ready),
        .o_mem_addr(o_mem_addr), .o_mem_wen(o_mem_wen),
        .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
        .i_mem_rsp_valid(i_mem_rsp_valid), .i_mem_rdata(i_mem_rdata),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
        .o_rdwen(o_rdwen), .o_rdid(o_rdid), .o_misalign(o_misalign)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model of one packet.
    task automatic model(input logic [3:0] op, input logic [63:0] addr,
                         input logic [63:0] sdata, input logic [63:0] rdata,
                         input logic rdwen,
                         output logic is_mem, output logic mis,
                         output logic [63:0] res, output logic exp_rdwen,
                         output logic [63:0] wdata, output logic [7:0] wmask,
                         output logic wen);
        int op_i, bytes, off;
        logic ld, st, sgn;
        logic [63:0] m64, v;
        op_i  = int'(op);
        ld    = (op_i >= 1) && (op_i <= 7);
        st    = (op_i >= 8) && (op_i <= 11);
        sgn   = (op_i >= 1) && (op_i <= 3);
        bytes = 1;
        if (ld) bytes = 1 << ((op_i <= 4) ? op_i - 1 : op_i - 5);
        if (st) bytes = 1 << (op_i - 8);
        off   = int'(addr[2:0]);
        mis   = (ld || st) && ((off % bytes) != 0);
        is_mem = (ld || st) && !mis;
        m64   = (bytes == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * bytes)) - 64'd1);
        wen   = st;
        wdata = st ? (sdata << (8 * off)) : 64'd0;
        wmask = st ? 8'(((1 << bytes) - 1) << off) : 8'd0;
        if (!is_mem) begin
            res = addr;
        end else if (st) begin
            res = 64'd0;
        end else begin
            v = (rdata >> (8 * off)) & m64;
            if (sgn && (((v >> (8 * bytes - 1)) & 64'd1) == 64'd1)) v = v | ~m64;
            res = v;
        end
        exp_rdwen = rdwen && !mis && !st;
    endtask

    task automatic run_pkt(input logic [3:0] op, input logic [63:0] addr,
                           input logic [63:0] sdata, input logic rdwen,
                           input logic [4:0] rdid, input logic [63:0] rdata,
                           input int req_dly, input int rsp_dly, input int wb_dly);
        logic is_mem, mis, e_rdwen, e_wen;
        logic [63:0] e_res, e_wdata;
        logic [7:0] e_wmask;
        model(op, addr, sdata, rdata, rdwen, is_mem, mis, e_res, e_rdwen, e_wdata, e_wmask, e_wen);
        check("ready_before_accept", 64'(o_ready), 64'd1);
        i_valid = 1'b1; i_op = op; i_alu_res = addr; i_sdata = sdata;
        i_rdwen = rdwen; i_rdid = rdid;
        tick();
        i_valid = 1'b0; i_op = 4'($urandom); i_alu_res = {$urandom, $urandom};
        i_sdata = {$urandom, $urandom}; i_rdwen = 1'($urandom); i_rdid = 5'($urandom);
        check("ready_after_accept", 64'(o_ready), 64'd0);
        if (is_mem) begin
            check("valid_in_req", 64'(o_valid), 64'd0);
            for (int k = 0; k <= req_dly; k++) begin
                check("req_valid", 64'(o_mem_req_valid), 64'd1);
                check("req_addr", o_mem_addr, {addr[63:3], 3'b000});
                check("req_wen", 64'(o_mem_wen), 64'(e_wen));
                check("req_wdata", o_mem_wdata, e_wdata);
                check("req_wmask", 64'(o_mem_wmask), 64'(e_wmask));
                if (k < req_dly) begin
                    i_mem_rsp_valid = 1'($urandom);
                    i_mem_rdata = {$urandom, $urandom};
                    tick();
                end
            end
            i_mem_rsp_valid = 1'b0;
            i_mem_req_ready = 1'b1;
            tick();
            i_mem_req_ready = 1'b0;
            for (int k = 0; k < rsp_dly; k++) begin
                check("wait_no_req", 64'(o_mem_req_valid), 64'd0);
                check("wait_no_valid", 64'(o_valid), 64'd0);
                tick();
            end
            check("wait_no_req", 64'(o_mem_req_valid), 64'd0);
            i_mem_rsp_valid = 1'b1;
            i_mem_rdata = rdata;
            tick();
            i_mem_rsp_valid = 1'b0;
            i_mem_rdata = {$urandom, $urandom};
        end else begin
            check("no_req_nonmem", 64'(o_mem_req_valid), 64'd0);
        end
        for (int k = 0; k <= wb_dly; k++) begin
            check("wb_valid", 64'(o_valid), 64'd1);
            check("wb_result", o_result, e_res);
            check("wb_rdwen", 64'(o_rdwen), 64'(e_rdwen));
            check("wb_rdid", 64'(o_rdid), 64'(rdid));
            check("wb_misalign", 64'(o_misalign), 64'(mis));
            check("wb_ready_low", 64'(o_ready), 64'd0);
            check("wb_no_req", 64'(o_mem_req_valid), 64'd0);
            if (k < wb_dly) tick();
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("after_wb_valid", 64'(o_valid), 64'd0);
        check("after_wb_ready", 64'(o_ready), 64'd1);
    endtask

    initial begin
        logic [3:0]  op;
        logic [63:0] addr;
        rst = 1'b1; i_valid = 1'b0; i_op = '0; i_alu_res = '0; i_sdata = '0;
        i_rdwen = 1'b0; i_rdid = '0; i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b0; i_mem_rdata = '0; i_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_req", 64'(o_mem_req_valid), 64'd0);
        check("rst_addr", o_mem_addr, 64'd0);
        check("rst_result", o_result, 64'd0);
        check("rst_misc", {o_mem_wdata[31:0], 8'(o_mem_wmask), 8'(o_rdid),
                           7'd0, o_mem_wen, 6'd0, o_rdwen, o_misalign}, 64'd0);

        // Directed cases.
        run_pkt(4'd0, 64'h1234, 64'd0, 1'b1, 5'd5, 64'd0, 0, 0, 0);
        run_pkt(4'd1, 64'h8000_0003, 64'd0, 1'b1, 5'd7, 64'h0000_0000_8000_0000, 0, 0, 0);
        check("lb_direct", o_result, 64'd0);
        run_pkt(4'd5, 64'h8000_0003, 64'd0, 1'b1, 5'd8, 64'h0000_0000_8000_0000, 0, 0, 0);
        run_pkt(4'd9, 64'h1000_0006, 64'hABCD, 1'b1, 5'd9, 64'd0, 0, 0, 0);
        run_pkt(4'd3, 64'h1000_0002, 64'd0, 1'b1, 5'd10, 64'd0, 0, 0, 0);
        run_pkt(4'd11, 64'h2000_0008, 64'h1122_3344_5566_7788, 1'b1, 5'd11, 64'd0, 3, 0, 0);
        run_pkt(4'd4, 64'h2000_0010, 64'd0, 1'b1, 5'd12, 64'hDEAD_BEEF_0BAD_F00D, 0, 2, 4);
        run_pkt(4'd14, 64'h5555_AAAA, 64'd0, 1'b1, 5'd13, 64'd0, 0, 0, 2);

        // Reset while waiting for a response; the late response must be ignored.
        i_valid = 1'b1; i_op = 4'd4; i_alu_res = 64'h100; i_rdwen = 1'b1; i_rdid = 5'd3;
        tick();
        i_valid = 1'b0;
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_wait_ready", 64'(o_ready), 64'd1);
        check("rst_wait_valid", 64'(o_valid), 64'd0);
        check("rst_wait_req", 64'(o_mem_req_valid), 64'd0);
        i_mem_rsp_valid = 1'b1; i_mem_rdata = 64'hFFFF_0000_FFFF_0000;
        tick();
        i_mem_rsp_valid = 1'b0;
        check("late_rsp_valid", 64'(o_valid), 64'd0);
        check("late_rsp_ready", 64'(o_ready), 64'd1);
        tick();
        check("late_rsp_valid2", 64'(o_valid), 64'd0);
        run_pkt(4'd2, 64'h3000_0004, 64'd0, 1'b1, 5'd20, 64'h0000_8001_0000_0000, 0, 0, 0);

        // Randomized packets.
        for (int n = 0; n < 120; n++) begin
            op   = 4'($urandom_range(0, 15));
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 0) addr[2:0] = 3'($urandom_range(0, 3) * 2 * $urandom_range(0, 1));
            run_pkt(op, addr, {$urandom, $urandom}, 1'($urandom), 5'($urandom),
                    {$urandom, $urandom}, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit sitting directly downstream of the execute-stage ALU.
- Consumes the ALU result as an effective address, or passes it through for non-memory ops.
- Performs one outstanding aligned access on a simple valid/ready data-memory port, aligns and extends load data, and presents a write-back packet to the WB stage under valid/ready.

Parameters:
- XLEN, 64, datapath/address width; only 64 is supported.
- OP_W, 4, width of the LSU op code.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_valid  in  1  upstream packet valid
- o_ready  out  1  LSU can accept a packet
- i_op  in  OP_W  0 NONE, 1 LB, 2 LH, 3 LW, 4 LD, 5 LBU, 6 LHU, 7 LWU, 8 SB, 9 SH, 10 SW, 11 SD; 12-15 are treated as NONE
- i_alu_res  in  XLEN  ALU result: address for memory ops, result for NONE
- i_sdata  in  XLEN  store data (rs2)
- i_rdwen  in  1  destination write enable
- i_rdid  in  5  destination register index
- o_mem_req_valid  out  1  memory request valid
- i_mem_req_ready  in  1  memory accepts request
- o_mem_addr  out  XLEN  8-byte-aligned address: {addr[63:3],3'b0}
- o_mem_wen  out  1  1 for store, 0 for load
- o_mem_wdata  out  XLEN  store data shifted into lane
- o_mem_wmask  out  8  byte-lane strobe
- i_mem_rsp_valid  in  1  read data valid, or write ack
- i_mem_rdata  in  XLEN  read data (full aligned doubleword)
- o_valid  out  1  write-back packet valid
- i_ready  in  1  WB stage accepts packet
- o_result  out  XLEN  load data or passthrough ALU result
- o_rdwen  out  1  registered i_rdwen; forced 0 for stores and misaligned ops
- o_rdid  out  5  registered i_rdid
- o_misalign  out  1  address misaligned for access size; no memory access made

Behaviour:
- FSM states: IDLE, REQ, WAIT, DONE. After reset: state IDLE, o_ready=1, every other output 0.
- o_ready = (state==IDLE). A packet is accepted when i_valid & o_ready. All inputs are registered at accept.
- IDLE, accept of NONE -> DONE. o_result=i_alu_res. Latency: accept at cycle N, o_valid at N+1.
- IDLE, accept of a memory op:
  - Misaligned -> DONE with o_misalign=1, o_rdwen=0, o_result=i_alu_res, no request issued.
  - Misaligned means: H and addr[0]!=0; W and addr[1:0]!=0; D and addr[2:0]!=0.
  - Aligned -> REQ.
- REQ: o_mem_req_valid=1. Address, wen, wdata and wmask are held stable until i_mem_req_ready. Handshake -> WAIT. i_mem_rsp_valid is ignored in REQ.
- WAIT: on i_mem_rsp_valid -> DONE.
  - Load: capture the aligned/extended result.
  - Store: the response is only an ack; o_result=0.
- DONE: o_valid=1 and all outputs held until i_ready, then -> IDLE. The next accept occurs no earlier than the cycle after the handshake; there is no back-to-back overlap.
- Minimum memory-op latency: accept N, req handshake N+1, rsp N+2, o_valid N+3.
- Load alignment:
  - off = addr[2:0]; sh = rdata >> (off*8).
  - B/H/W take sh[7:0]/[15:0]/[31:0].
  - LB/LH/LW sign-extend to 64 bits; LBU/LHU/LWU zero-extend; LD passes through.
- Store alignment:
  - wdata = sdata << (off*8).
  - wmask = (8'h01 / 8'h03 / 8'h0F / 8'hFF) << off, for B/H/W/D.
  - o_mem_wdata and o_mem_wmask are 0 for loads.
- Reset in any state:
  - Next state IDLE; o_mem_req_valid and o_valid drop the cycle after i_rst is sampled.
  - A response arriving after reset is ignored, because IDLE ignores i_mem_rsp_valid.
- o_valid never asserts without a matching accepted packet. Exactly one WB packet per accepted packet.

Test Plan:
- NONE op, i_alu_res=64'h1234, i_rdwen=1, i_rdid=5, i_ready=1 -> o_valid one cycle after accept, o_result=64'h1234, o_rdid=5, no mem request.
- LB addr 64'h8000_0003, rdata=64'h0000_0000_8000_0000, req_ready immediate, rsp next cycle:
  - o_mem_addr=64'h8000_0000, o_mem_wen=0.
  - o_result=64'hFFFF_FFFF_FFFF_FF80; with LBU instead, 64'h80.
- SH addr 64'h...06, sdata=64'hABCD -> o_mem_wmask=8'hC0, o_mem_wdata=64'hABCD_0000_0000_0000, o_mem_wen=1; o_rdwen=0 on completion.
- LW addr 64'h...02 -> o_misalign=1, o_rdwen=0, o_mem_req_valid never asserts, o_valid next cycle.
- Backpressure:
  - i_mem_req_ready low 3 cycles -> request fields stable throughout.
  - i_ready low 4 cycles in DONE -> o_valid and o_result held, o_ready=0.
- Reset in WAIT, then a late i_mem_rsp_valid pulse -> state IDLE, o_valid stays 0, next packet processes normally.
